// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a scan mode. In direct mode it decodes w.
// In scan mode an internal index visits every output in turn and holds each one
// for (dwell + 1) cycles.
module scan_decoder #(
    parameter int unsigned N       = 4,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       w,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    y,
    output logic [N-1:0]       idx,
    output logic               valid,
    output logic               wrap
);

    localparam int unsigned W = 2**N;

    localparam logic [N-1:0]       IdxOne = 1;
    localparam logic [N-1:0]       IdxMax = '1;
    localparam logic [DWELL_W-1:0] CntOne = 1;

    typedef enum logic [1:0] {
        StIdle,
        StDirect,
        StScan
    } state_e;

    state_e             state_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [N-1:0]       idx_next;

    // Binary select to one-hot vector.
    function automatic logic [W-1:0] decode(input logic [N-1:0] sel);
        logic [W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // Next scan index. This wraps naturally modulo 2**N.
    always_comb begin
        idx_next = idx + IdxOne;
    end

    // Mode FSM. All outputs are registered in the same block.
    // en=0 wins over mode. Any entry into scan restarts at index 0 and re-latches dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            y       <= '0;
            idx     <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
        end else begin
            wrap <= 1'b0;
            if (!en) begin
                state_q <= StIdle;
                y       <= '0;
                idx     <= '0;
                valid   <= 1'b0;
                cnt_q   <= '0;
            end else if (!mode) begin
                state_q <= StDirect;
                y       <= decode(w);
                idx     <= w;
                valid   <= 1'b1;
                cnt_q   <= '0;
            end else if (state_q != StScan) begin
                state_q <= StScan;
                y       <= decode('0);
                idx     <= '0;
                valid   <= 1'b1;
                cnt_q   <= '0;
                dwell_q <= dwell;
            end else if (cnt_q == dwell_q) begin
                y     <= decode(idx_next);
                idx   <= idx_next;
                cnt_q <= '0;
                wrap  <= (idx == IdxMax);
            end else begin
                cnt_q <= cnt_q + CntOne;
            end
        end
    end

endmodule
